// File: rtl/mul_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_seq_ctrl_if
// Description : Request/response handshake and multiplier-cell bus for the
//               multicycle 32x32 multiply controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface mul_seq_ctrl_if;
  // execute-stage request side
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic        flush;
  // result side
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  // shared 16x16 multiplier cell
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic        mul_en;
  logic [31:0] mul_p;

  // controller view
  modport slave (
    input  in_valid, in_op, in_src1, in_src2, flush, out_ready, mul_p,
    output in_ready, out_valid, out_result, mul_a, mul_b, mul_en
  );

  // execute stage plus multiplier cell view
  modport master (
    output in_valid, in_op, in_src1, in_src2, flush, out_ready, mul_p,
    input  in_ready, out_valid, out_result, mul_a, mul_b, mul_en
  );
endinterface
`default_nettype wire

// File: rtl/mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mul_seq_ctrl
// Description : Sequences one registered 16x16 unsigned multiplier through
//               four partial products to implement mul/mulxuu/mulxsu/mulxss.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_seq_ctrl #(
  parameter int MUL_LATENCY = 1   // 1 or 2 cycles, issue to product
) (
  input  logic         clk,
  input  logic         reset_n,
  mul_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_FIX   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] src1_q, src1_d;
  logic [31:0] src2_q, src2_d;
  logic [63:0] acc_q, acc_d;

  // Tag per issued partial product: {valid, weight code}. Weight code
  // 0/1/2 means shift by 0/16/32; code 2 is only ever the final product.
  logic [2:0]  tag_q [MUL_LATENCY];
  logic [2:0]  tag_d [MUL_LATENCY];
  logic [2:0]  tag_out;
  logic [1:0]  weight_code;
  logic        issue;
  logic [63:0] addend;
  logic [31:0] hi;

  assign issue   = (state_q == S_ISSUE);
  assign tag_out = tag_q[MUL_LATENCY-1];

  // Operand slicing and weight for the partial product being issued
  always_comb begin
    weight_code = 2'd1;
    if (cnt_q == 2'd0) weight_code = 2'd0;
    if (cnt_q == 2'd3) weight_code = 2'd2;
  end

  assign bus.mul_en     = issue;
  assign bus.mul_a      = issue ? (cnt_q[1] ? src1_q[31:16] : src1_q[15:0]) : 16'd0;
  assign bus.mul_b      = issue ? (cnt_q[0] ? src2_q[31:16] : src2_q[15:0]) : 16'd0;
  assign bus.in_ready   = (state_q == S_IDLE);
  assign bus.out_valid  = (state_q == S_DONE);
  assign bus.out_result = (state_q != S_DONE) ? 32'd0 :
                          (op_q == 2'd0) ? acc_q[31:0] : acc_q[63:32];

  // Product aligned to its weight before accumulation
  always_comb begin
    addend = {32'd0, bus.mul_p};
    case (tag_out[1:0])
      2'd1:    addend = {16'd0, bus.mul_p, 16'd0};
      2'd2:    addend = {bus.mul_p, 32'd0};
      default: addend = {32'd0, bus.mul_p};
    endcase
  end

  // Tag delay line tracking the multiplier pipeline; flush kills in-flight tags
  always_comb begin
    tag_d[0] = issue ? {1'b1, weight_code} : 3'b000;
    for (int i = 1; i < MUL_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    if (bus.flush) begin
      for (int i = 0; i < MUL_LATENCY; i++) begin
        tag_d[i] = 3'b000;
      end
    end
  end

  // Next-state, operand capture, accumulation and signed correction
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    acc_d   = acc_q;
    hi      = acc_q[63:32];
    if (tag_out[2]) begin
      acc_d = acc_q + addend;
    end
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && !bus.flush) begin
          op_d    = bus.in_op;
          src1_d  = bus.in_src1;
          src2_d  = bus.in_src2;
          acc_d   = 64'd0;
          cnt_d   = 2'd0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (tag_out[2] && (tag_out[1:0] == 2'd2)) state_d = S_FIX;
      end
      S_FIX: begin
        // Unsigned product minus the two's-complement sign terms
        if (op_q[1] && src1_q[31])         hi = hi - src2_q;
        if ((op_q == 2'd3) && src2_q[31])  hi = hi - src1_q;
        acc_d   = {hi, acc_q[31:0]};
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.flush) begin
      state_d = S_IDLE;
      cnt_d   = 2'd0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      op_q    <= 2'd0;
      src1_q  <= 32'd0;
      src2_q  <= 32'd0;
      acc_q   <= 64'd0;
      tag_q   <= '{default: 3'b000};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      acc_q   <= acc_d;
      tag_q   <= tag_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_seq_ctrl
// Description : Directed bench for mul_seq_ctrl, one instance per multiplier
//               latency (1 and 2) sharing the same request stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_seq_ctrl;

  logic clk;
  logic reset_n;
  int   n_assert;
  int   n_fail;

  mul_seq_ctrl_if i1 ();
  mul_seq_ctrl_if i2 ();

  mul_seq_ctrl #(.MUL_LATENCY(1)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(i1));
  mul_seq_ctrl #(.MUL_LATENCY(2)) u_dut2 (.clk(clk), .reset_n(reset_n), .bus(i2));

  // second instance sees exactly the same request/flush/ready stimulus
  assign i2.in_valid  = i1.in_valid;
  assign i2.in_op     = i1.in_op;
  assign i2.in_src1   = i1.in_src1;
  assign i2.in_src2   = i1.in_src2;
  assign i2.flush     = i1.flush;
  assign i2.out_ready = i1.out_ready;

  // registered 16x16 multiplier cells, one and two stages deep
  logic [31:0] p1_q, p2a_q, p2b_q;
  always_ff @(posedge clk) begin
    p1_q  <= {16'd0, i1.mul_a} * {16'd0, i1.mul_b};
    p2a_q <= {16'd0, i2.mul_a} * {16'd0, i2.mul_b};
    p2b_q <= p2a_q;
  end
  assign i1.mul_p = p1_q;
  assign i2.mul_p = p2b_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // present one request for a single edge; operands are scrambled afterwards
  task automatic accept(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    i1.in_valid = 1'b1;
    i1.in_op    = op;
    i1.in_src1  = a;
    i1.in_src2  = b;
    step();
    i1.in_valid = 1'b0;
    i1.in_op    = 2'd3;
    i1.in_src1  = 32'hDEAD_BEEF;
    i1.in_src2  = 32'h1234_5678;
  endtask

  // called just after the accepting edge (cycle 1); checks latency and value on both instances
  task automatic wait_result(input string tag, input logic [31:0] exp);
    int          lat1 = 0;
    int          lat2 = 0;
    logic [31:0] r1 = 32'd0;
    logic [31:0] r2 = 32'd0;
    for (int k = 2; k <= 14; k++) begin
      step();
      if (i1.out_valid && lat1 == 0) begin lat1 = k; r1 = i1.out_result; end
      if (i2.out_valid && lat2 == 0) begin lat2 = k; r2 = i2.out_result; end
    end
    chk({tag, " lat1"}, lat1, 32'd7);
    chk({tag, " res1"}, r1, exp);
    chk({tag, " lat2"}, lat2, 32'd8);
    chk({tag, " res2"}, r2, exp);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    chk({tag, " in_ready"}, {31'd0, i1.in_ready & i2.in_ready}, 32'd1);
    accept(op, a, b);
    wait_result(tag, exp);
  endtask

  initial begin
    logic any_valid;
    n_assert     = 0;
    n_fail       = 0;
    reset_n      = 1'b0;
    i1.in_valid  = 1'b0;
    i1.in_op     = 2'd0;
    i1.in_src1   = 32'd0;
    i1.in_src2   = 32'd0;
    i1.flush     = 1'b0;
    i1.out_ready = 1'b1;
    #2;
    chk("rst in_ready",   {31'd0, i1.in_ready},  32'd1);
    chk("rst out_valid",  {31'd0, i1.out_valid}, 32'd0);
    chk("rst mul_en",     {31'd0, i1.mul_en},    32'd0);
    chk("rst mul_ab",     {i1.mul_a, i1.mul_b},  32'd0);
    chk("rst out_result", i1.out_result,         32'd0);
    step();
    step();
    reset_n = 1'b1;
    step();

    // basic products, signed and unsigned variants
    run_op("t1 mulxuu -1",  2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("t1 mul -1",     2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op("t2 mul",        2'd0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F);
    run_op("t2 mulxuu",     2'd1, 32'h0001_0003, 32'h0002_0005, 32'h0000_0002);
    run_op("t3 mulxss -1",  2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    run_op("t3 mulxsu -1",  2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("t3 mulxss min", 2'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);

    // backpressure: result held, no acceptance in DONE, then back-to-back request
    i1.out_ready = 1'b0;
    accept(2'd0, 32'h0001_0003, 32'h0002_0005);
    for (int k = 2; k <= 7; k++) step();
    chk("bp valid", {31'd0, i1.out_valid}, 32'd1);
    i1.in_valid = 1'b1;
    i1.in_op    = 2'd1;
    i1.in_src1  = 32'hFFFF_FFFF;
    i1.in_src2  = 32'hFFFF_FFFF;
    for (int k = 0; k < 5; k++) begin
      chk("bp hold result", i1.out_result, 32'h000B_000F);
      chk("bp hold state", {30'd0, i1.out_valid, i1.in_ready}, 32'd2);
      if (k < 4) step();
    end
    i1.out_ready = 1'b1;
    step();
    chk("bp after hs", {30'd0, i1.out_valid, i1.in_ready}, 32'd1);
    step();
    i1.in_valid = 1'b0;
    wait_result("bp b2b", 32'hFFFF_FFFE);

    // flush in the third issue cycle
    accept(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step();
    step();
    i1.flush = 1'b1;
    step();
    i1.flush = 1'b0;
    chk("flush in_ready", {31'd0, i1.in_ready & i2.in_ready}, 32'd1);
    chk("flush mul_en",   {31'd0, i1.mul_en | i2.mul_en},     32'd0);
    any_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      any_valid = any_valid | i1.out_valid | i2.out_valid;
      step();
    end
    chk("flush no valid", {31'd0, any_valid}, 32'd0);
    run_op("flush next", 2'd1, 32'd3, 32'd5, 32'h0000_0000);

    // asynchronous reset during DRAIN
    accept(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int k = 0; k < 4; k++) step();
    chk("drain not ready", {31'd0, i1.in_ready}, 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst in_ready",  {31'd0, i1.in_ready & i2.in_ready}, 32'd1);
    chk("arst valid_en",  {30'd0, i1.out_valid, i1.mul_en},   32'd0);
    chk("arst mul_ab",    {i1.mul_a, i1.mul_b},               32'd0);
    chk("arst result",    i1.out_result,                      32'd0);
    step();
    reset_n = 1'b1;
    step();
    run_op("arst next", 2'd1, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
